// File: rtl/i2c_codec_target_if.sv
// Register-side bus of the I2C codec target: write strobe, last write, shadow readback and status.
interface i2c_codec_target_if;
  logic       reg_wr;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [3:0] rd_addr;
  logic [8:0] rd_data;
  logic       active;
  logic       busy;

  modport slave (
    output reg_wr, reg_addr, reg_data, rd_data, active, busy,
    input  rd_addr
  );

  modport master (
    input  reg_wr, reg_addr, reg_data, rd_data, active, busy,
    output rd_addr
  );
endinterface

// File: rtl/i2c_codec_target.sv
// I2C write-only target for codec control: decodes 2-byte register writes (7-bit reg, 9-bit data)
// and keeps a shadow copy of registers R0..R9.
module i2c_codec_target #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic clk,
  input  logic reset,
  input  logic scl,
  inout  wire  sda,
  i2c_codec_target_if.slave bus
);

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned CNT_W     = 4;
  localparam int unsigned ADDR_W    = 7;
  localparam int unsigned REG_W     = 9;
  localparam int unsigned NUM_REGS  = 10;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ACK_A, S_BYTE1, S_ACK_1, S_BYTE2, S_ACK_2, S_IGNORE
  } state_t;

  function automatic logic [REG_W-1:0] reg_default(input int unsigned idx);
    case (idx)
      0, 1:    reg_default = 9'h097;
      2, 3:    reg_default = 9'h079;
      4:       reg_default = 9'h00A;
      5:       reg_default = 9'h008;
      6:       reg_default = 9'h09F;
      7:       reg_default = 9'h00A;
      default: reg_default = 9'h000;
    endcase
  endfunction

  logic scl_meta, scl_s, scl_d;
  logic sda_meta, sda_s, sda_d;

  state_t                state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [BYTE_BITS-1:0]  shreg;
  logic [BYTE_BITS-1:0]  byte1;
  logic                  sda_oe;
  logic                  reg_wr_q;
  logic [ADDR_W-1:0]     reg_addr_q;
  logic [REG_W-1:0]      reg_data_q;
  logic                  busy_q;
  logic [REG_W-1:0]      shadow [NUM_REGS];
  logic [REG_W-1:0]      rd_data_c;

  logic scl_rise_c, scl_fall_c, start_c, stop_c, bit_done_c, wr_fire_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [REG_W-1:0]  wr_data_c;

  // Open-drain: only ever pull low
  assign sda = sda_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= 1'b1; scl_s <= 1'b1; scl_d <= 1'b1;
      sda_meta <= 1'b1; sda_s <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_meta <= scl;  scl_s <= scl_meta; scl_d <= scl_s;
      sda_meta <= sda;  sda_s <= sda_meta; sda_d <= sda_s;
    end
  end

  assign scl_rise_c = scl_s & ~scl_d;
  assign scl_fall_c = ~scl_s & scl_d;
  assign start_c    = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c     = scl_s & scl_d & ~sda_d & sda_s;
  assign bit_done_c = scl_fall_c && (bit_cnt == CNT_W'(BYTE_BITS));
  assign wr_addr_c  = byte1[7:1];
  assign wr_data_c  = {byte1[0], shreg};
  assign wr_fire_c  = (state == S_BYTE2) && bit_done_c && !start_c && !stop_c;

  // Protocol FSM; START/STOP override every state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte1      <= '0;
      sda_oe     <= 1'b0;
      reg_wr_q   <= 1'b0;
      reg_addr_q <= '0;
      reg_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      reg_wr_q <= 1'b0;
      if (start_c) begin
        state   <= S_ADDR;
        bit_cnt <= '0;
        sda_oe  <= 1'b0;
        busy_q  <= 1'b1;
      end else if (stop_c) begin
        state  <= S_IDLE;
        sda_oe <= 1'b0;
        busy_q <= 1'b0;
      end else begin
        case (state)
          S_ADDR, S_BYTE1, S_BYTE2: begin
            if (scl_rise_c && (bit_cnt < CNT_W'(BYTE_BITS))) begin
              shreg   <= {shreg[BYTE_BITS-2:0], sda_s};
              bit_cnt <= bit_cnt + CNT_W'(1);
            end else if (bit_done_c) begin
              bit_cnt <= '0;
              if (state == S_ADDR) begin
                if (shreg == {DEV_ADDR, 1'b0}) begin
                  state  <= S_ACK_A;
                  sda_oe <= 1'b1;
                end else begin
                  state <= S_IGNORE;
                end
              end else if (state == S_BYTE1) begin
                byte1  <= shreg;
                state  <= S_ACK_1;
                sda_oe <= 1'b1;
              end else begin
                state      <= S_ACK_2;
                sda_oe     <= 1'b1;
                reg_wr_q   <= 1'b1;
                reg_addr_q <= wr_addr_c;
                reg_data_q <= wr_data_c;
              end
            end
          end
          S_ACK_A: if (scl_fall_c) begin state <= S_BYTE1;  sda_oe <= 1'b0; end
          S_ACK_1: if (scl_fall_c) begin state <= S_BYTE2;  sda_oe <= 1'b0; end
          S_ACK_2: if (scl_fall_c) begin state <= S_IGNORE; sda_oe <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

  // Shadow registers follow the write in the same cycle reg_wr rises; reg 15 restores defaults
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= reg_default(i);
    end else if (wr_fire_c) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_addr_c == 7'd15)               shadow[i] <= reg_default(i);
        else if (wr_addr_c == ADDR_W'(i))     shadow[i] <= wr_data_c;
      end
    end
  end

  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (bus.rd_addr == CNT_W'(i)) rd_data_c = shadow[i];
    end
  end

  assign bus.reg_wr   = reg_wr_q;
  assign bus.reg_addr = reg_addr_q;
  assign bus.reg_data = reg_data_q;
  assign bus.busy     = busy_q;
  assign bus.rd_data  = rd_data_c;
  assign bus.active   = shadow[9][0];

endmodule

// File: tb/tb_i2c_codec_target.sv
// Bit-banged I2C initiator with a transaction-level model of the codec target's writes and shadow registers.
module tb_i2c_codec_target;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic scl = 1'b1;
  logic tb_sda_low = 1'b0;
  wire  sda;

  pullup (sda);
  assign sda = tb_sda_low ? 1'b0 : 1'bz;

  i2c_codec_target_if bus ();

  i2c_codec_target #(.DEV_ADDR(7'h1A)) dut (
    .clk   (clk),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .bus   (bus.slave)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int wr_count = 0;

  logic [8:0]  def_tab  [10];
  logic [8:0]  m_shadow [10];
  logic [6:0]  m_addr;
  logic [8:0]  m_data;
  logic [15:0] exp_q [$];
  bit          ack_window = 1'b0;
  bit          rd_hold = 1'b0;
  logic [3:0]  rd_sel = 4'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sole driver of rd_addr: random index unless the main flow pins one
  always begin
    @(posedge clk);
    #1;
    bus.rd_addr = rd_hold ? rd_sel : 4'($urandom_range(0, 15));
  end

  // Per-cycle comparison of DUT outputs against the transaction model
  always @(negedge clk) begin
    logic [15:0] e;
    logic [8:0]  exp_rd;
    if (reset) begin
      for (int i = 0; i < 10; i++) m_shadow[i] = def_tab[i];
      m_addr = '0;
      m_data = '0;
      check("reg_wr_in_reset", 32'(bus.reg_wr), 32'd0);
      check("busy_in_reset", 32'(bus.busy), 32'd0);
    end else if (bus.reg_wr) begin
      wr_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_reg_wr", 32'(bus.reg_wr), 32'd0);
      end else begin
        e = exp_q.pop_front();
        m_addr = e[15:9];
        m_data = e[8:0];
        if (m_addr < 7'd10) m_shadow[m_addr] = m_data;
        else if (m_addr == 7'd15) for (int i = 0; i < 10; i++) m_shadow[i] = def_tab[i];
      end
    end
    check("reg_addr", 32'(bus.reg_addr), 32'(m_addr));
    check("reg_data", 32'(bus.reg_data), 32'(m_data));
    exp_rd = (bus.rd_addr < 4'd10) ? m_shadow[bus.rd_addr] : 9'd0;
    check("rd_data", 32'(bus.rd_data), 32'(exp_rd));
    check("active", 32'(bus.active), 32'(m_shadow[9][0]));
    if (!tb_sda_low && !ack_window) check("sda_released", 32'(sda), 32'd1);
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "watchdog");
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int ph();
    return int'($urandom_range(8, 12));
  endfunction

  // START, or repeated START when SCL is currently low
  task automatic bus_start();
    if (scl == 1'b0) begin
      clks(ph() / 2);
      tb_sda_low = 1'b0;
      clks(ph() / 2);
      scl = 1'b1;
    end
    clks(ph() / 2);
    tb_sda_low = 1'b1;
    clks(ph());
    scl = 1'b0;
    check("busy_after_start", 32'(bus.busy), 32'd1);
  endtask

  task automatic bus_stop();
    clks(ph() / 2);
    tb_sda_low = 1'b1;
    clks(ph() / 2);
    scl = 1'b1;
    clks(ph() / 2);
    tb_sda_low = 1'b0;
    clks(ph());
    check("busy_after_stop", 32'(bus.busy), 32'd0);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      clks(ph() / 2);
      tb_sda_low = ~b[i];
      clks(ph() / 2);
      scl = 1'b1;
      clks(ph());
      if (i == 0) ack_window = 1'b1;
      scl = 1'b0;
    end
  endtask

  task automatic ack_bit(output logic acked, input bit rst_mid);
    clks(ph() / 2);
    tb_sda_low = 1'b0;
    clks(ph() / 2);
    scl = 1'b1;
    clks(ph() / 2);
    acked = (sda == 1'b0);
    if (rst_mid) begin
      @(posedge clk);
      #1 reset = 1'b1;
      #2 check("sda_async_release", 32'(sda), 32'd1);
      clks(4);
      reset = 1'b0;
      clks(6);
      ack_window = 1'b0;
    end else begin
      clks(ph() / 2);
      scl = 1'b0;
      clks(ph() / 2);
      ack_window = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit exp_ack, input string nm);
    logic a;
    send_bits(b, 8);
    ack_bit(a, 1'b0);
    check(nm, 32'(a), 32'(exp_ack));
  endtask

  // Whole transaction; ACKs and the queued write follow from the byte sequence alone
  task automatic txn(input logic [7:0] bs [4], input int n, input bit do_stop);
    bit addr_ok;
    bit exp_ack;
    bus_start();
    addr_ok = (bs[0] == 8'h34);
    for (int k = 0; k < n; k++) begin
      exp_ack = (k == 0) ? addr_ok : (addr_ok && k <= 2);
      if (k == 2 && addr_ok) exp_q.push_back({bs[1][7:1], bs[1][0], bs[2]});
      send_byte(bs[k], exp_ack, $sformatf("ack_byte%0d", k));
    end
    if (do_stop) bus_stop();
  endtask

  task automatic read_check(input logic [3:0] a, input logic [8:0] e, input string nm);
    rd_hold = 1'b1;
    rd_sel  = a;
    clks(2);
    check(nm, 32'(bus.rd_data), 32'(e));
    rd_hold = 1'b0;
  endtask

  initial begin
    logic [7:0] bs [4];
    logic       a;
    int         w0;
    bit         stopped;

    def_tab = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
    clks(5);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_reg_addr", 32'(bus.reg_addr), 32'd0);
    read_check(4'd0, 9'h097, "reset_r0");
    read_check(4'd6, 9'h09F, "reset_r6");
    read_check(4'd12, 9'h000, "reset_r12");
    reset = 1'b0;
    clks(5);

    // Basic write: reg 6 <= 0x06A
    w0 = wr_count;
    bs = '{8'h34, 8'h0C, 8'h6A, 8'h00};
    txn(bs, 3, 1'b1);
    check("w6_count", 32'(wr_count - w0), 32'd1);
    check("w6_addr", 32'(bus.reg_addr), 32'd6);
    check("w6_data", 32'(bus.reg_data), 32'h06A);
    check("model_r6", 32'(m_shadow[6]), 32'h06A);
    read_check(4'd6, 9'h06A, "w6_rd");

    // R9 bit 0 drives active; reg 15 restores defaults
    bs = '{8'h34, 8'h12, 8'h01, 8'h00};
    txn(bs, 3, 1'b1);
    check("w9_addr", 32'(bus.reg_addr), 32'd9);
    check("w9_data", 32'(bus.reg_data), 32'h001);
    check("w9_active", 32'(bus.active), 32'd1);
    bs = '{8'h34, 8'h1E, 8'h00, 8'h00};
    txn(bs, 3, 1'b1);
    check("w15_addr", 32'(bus.reg_addr), 32'd15);
    check("w15_active", 32'(bus.active), 32'd0);
    read_check(4'd6, 9'h09F, "w15_r6");
    read_check(4'd2, 9'h079, "w15_r2");

    // Wrong address and read bit: never acknowledged
    w0 = wr_count;
    bs = '{8'h36, 8'h12, 8'h01, 8'h00};
    txn(bs, 3, 1'b1);
    bs = '{8'h35, 8'h12, 8'h01, 8'h00};
    txn(bs, 2, 1'b1);
    check("nack_count", 32'(wr_count - w0), 32'd0);

    // STOP after byte1, then repeated START in mid byte2
    bs = '{8'h34, 8'h0E, 8'h00, 8'h00};
    txn(bs, 2, 1'b1);
    check("abort_count", 32'(wr_count - w0), 32'd0);
    check("abort_addr", 32'(bus.reg_addr), 32'd15);
    check("abort_data", 32'(bus.reg_data), 32'd0);
    bus_start();
    send_byte(8'h34, 1'b1, "rs_ack_a");
    send_byte(8'h0A, 1'b1, "rs_ack_1");
    send_bits(8'h55, 4);
    bs = '{8'h34, 8'h0A, 8'h55, 8'h00};
    txn(bs, 3, 1'b1);
    check("rs_count", 32'(wr_count - w0), 32'd1);
    check("rs_addr", 32'(bus.reg_addr), 32'd5);
    check("rs_data", 32'(bus.reg_data), 32'h055);

    // Extra byte after a write is NACKed
    w0 = wr_count;
    bs = '{8'h34, 8'h08, 8'h1E, 8'h55};
    txn(bs, 4, 1'b1);
    check("x4_count", 32'(wr_count - w0), 32'd1);
    check("x4_addr", 32'(bus.reg_addr), 32'd4);
    check("x4_data", 32'(bus.reg_data), 32'h01E);

    // Reset while the target drives ACK of byte1
    w0 = wr_count;
    bus_start();
    send_byte(8'h34, 1'b1, "rst_ack_a");
    send_bits(8'h0C, 8);
    ack_bit(a, 1'b1);
    check("rst_ack1_driven", 32'(a), 32'd1);
    check("rst_count", 32'(wr_count - w0), 32'd0);
    check("rst_addr", 32'(bus.reg_addr), 32'd0);
    bs = '{8'h34, 8'h0C, 8'h6A, 8'h00};
    txn(bs, 3, 1'b1);
    check("post_rst_count", 32'(wr_count - w0), 32'd1);
    read_check(4'd6, 9'h06A, "post_rst_r6");

    // Randomized transactions
    stopped = 1'b1;
    for (int t = 0; t < 24; t++) begin
      int r;
      bs[0] = ($urandom_range(0, 9) < 7) ? 8'h34 : 8'($urandom_range(0, 255));
      r = int'($urandom_range(0, 12));
      bs[1] = {(r <= 9) ? 7'(r) : ((r == 10) ? 7'd15 : 7'($urandom_range(0, 127))), 1'($urandom_range(0, 1))};
      bs[2] = 8'($urandom_range(0, 255));
      bs[3] = 8'($urandom_range(0, 255));
      stopped = ($urandom_range(0, 3) != 0);
      txn(bs, int'($urandom_range(1, 4)), stopped);
    end
    if (!stopped) bus_stop();
    clks(5);
    check("exp_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
